// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the memory access sequencer: bus widths, the default
// timeout and the width of the REQ-phase wait counter.
package mem_access_ctrl_pkg;

   localparam int ADDRESS_BUS_WIDTH   = 16;
   localparam int DATA_BUS_WIDTH      = 16;
   localparam int MEM_TIMEOUT_DEFAULT = 15;
   localparam int CTR_WIDTH           = 8;

   // Counter value at which a REQ phase without ack is abandoned.
   // A zero timeout disables the abort, so the value returned is then unused.
   function automatic logic [CTR_WIDTH-1:0] timeout_terminal(input int cycles);
      if (cycles == 0)
         return '0;
      return CTR_WIDTH'(cycles - 1);
   endfunction

endpackage

// File: rtl/mem_access_ctrl_timeout_ctr.sv
// 8-bit wait counter for the REQ phase: synchronous clear, count enable,
// saturates at all-ones, and flags when it equals the terminal value.
module mem_timeout_ctr
   import mem_access_ctrl_pkg::*;
#(
   parameter int W = CTR_WIDTH
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] terminal,
   output logic [W-1:0] count,
   output logic         tc
);

   // Count REQ cycles; hold at all-ones so a disabled timeout never wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && (count != {W{1'b1}}))
         count <= count + 1'b1;
   end

   assign tc = (count == terminal);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: latches address/data on start, runs one req/ack
// transaction with an optional timeout, captures read data into the MDR and
// pulses done (with error on timeout). All outputs are registered.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W         = ADDRESS_BUS_WIDTH,
   parameter int DATA_W         = DATA_BUS_WIDTH,
   parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              write_en,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata_in,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [DATA_W-1:0] mdr_out,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CTR_WIDTH-1:0] TERMINAL   = timeout_terminal(TIMEOUT_CYCLES);
   localparam logic                 TIMEOUT_ON = (TIMEOUT_CYCLES != 0);

   logic [1:0]           state;
   logic [1:0]           state_next;
   logic                 we_lat;
   logic                 ctr_clr;
   logic                 ctr_en;
   logic                 ctr_tc;
   logic [CTR_WIDTH-1:0] ctr_count;
   logic                 accept;
   logic                 ack_hit;
   logic                 timeout_hit;
   logic                 busy_next;
   logic                 req_next;
   logic                 we_next;
   logic                 done_next;
   logic                 error_next;

   // A new access is only accepted from IDLE; ack beats a same-cycle timeout.
   assign accept      = (state == IDLE) && start;
   assign ack_hit     = (state == REQ) && mem_ack;
   assign timeout_hit = (state == REQ) && !mem_ack && TIMEOUT_ON && ctr_tc;

   assign ctr_clr = accept;
   assign ctr_en  = (state == REQ) && !mem_ack;

   mem_timeout_ctr #(
      .W (CTR_WIDTH)
   ) u_timeout_ctr (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (ctr_clr),
      .en       (ctr_en),
      .terminal (TERMINAL),
      .count    (ctr_count),
      .tc       (ctr_tc)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state decode; the unused code 3 falls back to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = REQ;
         REQ:     if (ack_hit || timeout_hit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode from the upcoming state so the outputs can be registered.
   always_comb begin
      busy_next  = (state_next == REQ) || (state_next == DONE);
      req_next   = (state_next == REQ);
      we_next    = (state_next == REQ) && (accept ? write_en : we_lat);
      done_next  = (state_next == DONE);
      error_next = timeout_hit;
   end

   // Registered control outputs; async reset drops mem_req immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy    <= 1'b0;
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         busy    <= busy_next;
         mem_req <= req_next;
         mem_we  <= we_next;
         done    <= done_next;
         error   <= error_next;
      end
   end

   // Request latches load on accept; MDR loads only on an acknowledged read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         we_lat    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mdr_out   <= '0;
      end else begin
         if (accept) begin
            we_lat    <= write_en;
            mem_addr  <= addr_in;
            mem_wdata <= wdata_in;
         end
         if (ack_hit && !we_lat)
            mdr_out <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a fixed table of directed transactions, a reset
// abort sequence, then randomized transactions checked against a
// transaction-level model of the sequencer.
module tb_mem_access_ctrl;

   localparam int TMO    = 15;
   localparam int NO_ACK = 1000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        write_en = 1'b0;
   logic        mem_ack = 1'b0;
   logic [15:0] addr_in = '0;
   logic [15:0] wdata_in = '0;
   logic [15:0] mem_rdata = '0;
   logic        busy, done, error, mem_req, mem_we;
   logic [15:0] mdr_out, mem_addr, mem_wdata;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] model_mdr = '0;

   typedef struct {
      string       name;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          ack_at;
      logic [15:0] rdata;
      bit          poke;
      logic        exp_err;
      int          exp_req;
      logic [15:0] exp_mdr;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   mem_access_ctrl #(
      .ADDR_W         (16),
      .DATA_W         (16),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .write_en  (write_en),
      .addr_in   (addr_in),
      .wdata_in  (wdata_in),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .mdr_out   (mdr_out),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level reference: an ack within the first TMO REQ cycles
   // completes the access, otherwise it aborts after exactly TMO cycles.
   function automatic void model_txn(input logic we, input int ack_at, input logic [15:0] rdata,
                                     inout logic [15:0] mdr, output logic err, output int req_cycles);
      if (ack_at < TMO) begin
         err        = 1'b0;
         req_cycles = ack_at + 1;
         if (!we)
            mdr = rdata;
      end else begin
         err        = 1'b1;
         req_cycles = TMO;
      end
   endfunction

   // Drive one access and watch it cycle by cycle until the sequencer is idle.
   // With poke set, start is held and addr/data are scrambled while busy, and
   // stray acks are presented in DONE and IDLE.
   task automatic run_txn(input string tag, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int ack_at, input logic [15:0] rdata,
                          input bit poke, input logic exp_err, input int exp_req,
                          input logic [15:0] exp_mdr);
      int cyc      = 0;
      int reqc     = 0;
      int donec    = 0;
      int done_cyc = -1;
      bit finished = 0;
      @(negedge clk);
      start    = 1'b1;
      write_en = we;
      addr_in  = addr;
      wdata_in = wdata;
      @(posedge clk);
      while (!finished && cyc < 300) begin
         @(negedge clk);
         cyc++;
         start     = poke && busy;
         mem_ack   = 1'b0;
         mem_rdata = 16'($urandom);
         if (poke) begin
            addr_in  = 16'hFFFF;
            wdata_in = ~wdata;
            write_en = ~we;
         end
         if (mem_req) begin
            reqc++;
            chk({tag, ".mem_we"}, 32'(mem_we), 32'(we));
            chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
            chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(wdata));
            chk({tag, ".busy_req"}, 32'(busy), 32'd1);
            chk({tag, ".done_in_req"}, 32'(done), 32'd0);
            if (reqc - 1 == ack_at) begin
               mem_ack   = 1'b1;
               mem_rdata = rdata;
            end
         end else if (done) begin
            donec++;
            done_cyc = cyc;
            chk({tag, ".error"}, 32'(error), 32'(exp_err));
            chk({tag, ".mdr"}, 32'(mdr_out), 32'(exp_mdr));
            chk({tag, ".busy_done"}, 32'(busy), 32'd1);
            if (poke) mem_ack = 1'b1;
         end else if (!busy) begin
            finished = 1;
            if (poke) mem_ack = 1'b1;
         end else begin
            chk({tag, ".busy_without_req_or_done"}, 32'(busy), 32'd0);
         end
      end
      if (!finished)
         chk({tag, ".finished_within_budget"}, 32'(finished), 32'd1);
      chk({tag, ".req_cycles"}, 32'(reqc), 32'(exp_req));
      chk({tag, ".done_pulses"}, 32'(donec), 32'd1);
      chk({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_req + 1));
      @(negedge clk);
      mem_ack = 1'b0;
      chk({tag, ".mdr_after"}, 32'(mdr_out), 32'(exp_mdr));
      chk({tag, ".idle_req"}, 32'(mem_req), 32'd0);
      $display("txn %s we=%0d addr=%h ack_at=%0d req=%0d err=%0d mdr=%h", tag, we, addr,
               ack_at, reqc, error, mdr_out);
   endtask

   initial begin
      vecs[0] = '{"rd_zero_wait", 1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF, 1'b0, 1'b0, 1, 16'hBEEF};
      vecs[1] = '{"wr_3_wait", 1'b1, 16'h0100, 16'h1234, 3, 16'h7777, 1'b0, 1'b0, 4, 16'hBEEF};
      vecs[2] = '{"rd_timeout", 1'b0, 16'h0200, 16'h0000, NO_ACK, 16'h0000, 1'b0, 1'b1, 15, 16'hBEEF};
      vecs[3] = '{"start_busy", 1'b0, 16'h0040, 16'h0000, 2, 16'h5A5A, 1'b1, 1'b0, 3, 16'h5A5A};
      vecs[4] = '{"ack_on_tmo", 1'b0, 16'h0300, 16'h0000, 14, 16'hC3C3, 1'b0, 1'b0, 15, 16'hC3C3};
      vecs[5] = '{"wr_timeout", 1'b1, 16'h0400, 16'hA5A5, NO_ACK, 16'h0000, 1'b1, 1'b1, 15, 16'hC3C3};

      // Reset state.
      #2;
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.done", 32'(done), 32'd0);
      chk("reset.error", 32'(error), 32'd0);
      chk("reset.mem_req", 32'(mem_req), 32'd0);
      chk("reset.mem_we", 32'(mem_we), 32'd0);
      chk("reset.mdr", 32'(mdr_out), 32'd0);
      chk("reset.mem_addr", 32'(mem_addr), 32'd0);
      chk("reset.mem_wdata", 32'(mem_wdata), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ack_at,
                 vecs[i].rdata, vecs[i].poke, vecs[i].exp_err, vecs[i].exp_req, vecs[i].exp_mdr);
         model_mdr = vecs[i].exp_mdr;
      end

      // Reset in the middle of REQ abandons the access.
      @(negedge clk);
      start    = 1'b1;
      write_en = 1'b0;
      addr_in  = 16'h0ABC;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid.req_before", 32'(mem_req), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid.req", 32'(mem_req), 32'd0);
      chk("rst_mid.busy", 32'(busy), 32'd0);
      chk("rst_mid.mdr", 32'(mdr_out), 32'd0);
      chk("rst_mid.addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_mid.no_done", 32'(done), 32'd0);
         chk("rst_mid.idle", 32'(busy), 32'd0);
      end
      $display("txn rst_mid aborted access, mdr=%h", mdr_out);
      model_mdr = '0;
      run_txn("after_rst", 1'b0, 16'h0040, 16'h0000, 1, 16'h1357, 1'b0, 1'b0, 2, 16'h1357);
      model_mdr = 16'h1357;

      // Randomized transactions against the reference model.
      for (int n = 0; n < 30; n++) begin
         logic        r_we;
         logic [15:0] r_addr, r_wdata, r_rdata, r_mdr;
         int          r_ack, r_req;
         logic        r_err;
         bit          r_poke;
         r_we    = 1'($urandom_range(0, 1));
         r_addr  = 16'($urandom);
         r_wdata = 16'($urandom);
         r_rdata = 16'($urandom);
         r_poke  = 1'($urandom_range(0, 1));
         r_ack   = ($urandom_range(0, 3) == 0) ? NO_ACK : int'($urandom_range(0, 18));
         r_mdr   = model_mdr;
         model_txn(r_we, r_ack, r_rdata, r_mdr, r_err, r_req);
         run_txn($sformatf("rand%0d", n), r_we, r_addr, r_wdata, r_ack, r_rdata, r_poke,
                 r_err, r_req, r_mdr);
         model_mdr = r_mdr;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
